// File: rtl/ctrl_pkg.sv
// Shared encodings for the polynomial controller: FSM states, operand-mux
// selects and ALU op codes as seen by the datapath.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADX = 3'd1,
        AX    = 3'd2,
        ADDB  = 3'd3,
        MULX  = 3'd4,
        ADDC  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // constant select (m0)
    localparam logic [1:0] K_ZERO = 2'b00;
    localparam logic [1:0] K_A    = 2'b01;
    localparam logic [1:0] K_B    = 2'b10;
    localparam logic [1:0] K_C    = 2'b11;

    // operand-1 mux (m1)
    localparam logic [1:0] M1_CONST = 2'b00;
    localparam logic [1:0] M1_X     = 2'b01;
    localparam logic [1:0] M1_S     = 2'b10;
    localparam logic [1:0] M1_H     = 2'b11;

    // operand-2 mux (m2)
    localparam logic [1:0] M2_X     = 2'b00;
    localparam logic [1:0] M2_CONST = 2'b01;
    localparam logic [1:0] M2_S     = 2'b10;
    localparam logic [1:0] M2_H     = 2'b11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/ctrl_lat_cnt.sv
// Loadable down-counter that flags the final cycle of a multi-cycle step.
// Loading LAT-1 on entry makes last rise exactly on the step's LAT-th cycle.
module ctrl_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ck) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/poly_ctrl.sv
// Moore controller sequencing the polynomial datapath through the Horner
// evaluation Y = ((A*X) + B)*X + C, leaving the result in Reg_S.
module poly_ctrl
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       done
);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_LAT - 1);

    state_t           state;
    state_t           state_n;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             last;

    ctrl_lat_cnt #(
        .CNT_W(CNT_W)
    ) u_lat_cnt (
        .ck      (ck),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .last    (last)
    );

    always_ff @(posedge ck) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Every transition reloads the counter with the next state's LAT-1,
    // so the count always starts fresh on a state change.
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = LOADX;
                    cnt_load = 1'b1;
                end
            end
            LOADX: begin
                state_n  = AX;
                cnt_load = 1'b1;
                cnt_val  = MUL_LD;
            end
            AX: begin
                if (last) begin
                    state_n  = ADDB;
                    cnt_load = 1'b1;
                    cnt_val  = ADD_LD;
                end
            end
            ADDB: begin
                if (last) begin
                    state_n  = MULX;
                    cnt_load = 1'b1;
                    cnt_val  = MUL_LD;
                end
            end
            MULX: begin
                if (last) begin
                    state_n  = ADDC;
                    cnt_load = 1'b1;
                    cnt_val  = ADD_LD;
                end
            end
            ADDC: begin
                if (last) begin
                    state_n  = DONE;
                    cnt_load = 1'b1;
                end
            end
            DONE: begin
                state_n  = IDLE;
                cnt_load = 1'b1;
            end
            default: begin
                state_n  = IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    // Mux selects and op stay steady for the whole step; only the load
    // strobe waits for the counter's last cycle.
    always_comb begin
        busy = 1'b0;
        lx   = 1'b0;
        m0   = K_ZERO;
        m1   = M1_CONST;
        m2   = M2_X;
        h    = OP_ADD;
        ls   = 1'b0;
        lh   = 1'b0;
        done = 1'b0;
        case (state)
            LOADX: begin
                busy = 1'b1;
                lx   = 1'b1;
            end
            AX: begin
                busy = 1'b1;
                m0   = K_A;
                m1   = M1_CONST;
                m2   = M2_X;
                h    = OP_MUL;
                lh   = last;
            end
            ADDB: begin
                busy = 1'b1;
                m0   = K_B;
                m1   = M1_H;
                m2   = M2_CONST;
                h    = OP_ADD;
                lh   = last;
            end
            MULX: begin
                busy = 1'b1;
                m1   = M1_H;
                m2   = M2_X;
                h    = OP_MUL;
                lh   = last;
            end
            ADDC: begin
                busy = 1'b1;
                m0   = K_C;
                m1   = M1_H;
                m2   = M2_CONST;
                h    = OP_ADD;
                ls   = last;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_poly_ctrl.sv
// Directed bench for poly_ctrl: two instances (default and slow latencies),
// a 16-bit datapath model driven by the controls, and a done scoreboard.
module tb_poly_ctrl;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       rst;
    logic       start_a, start_b;
    logic       busy_a, lx_a, h_a, ls_a, lh_a, done_a;
    logic [1:0] m0_a, m1_a, m2_a;
    logic       busy_b, lx_b, h_b, ls_b, lh_b, done_b;
    logic [1:0] m0_b, m1_b, m2_b;

    poly_ctrl u_a (
        .ck(ck), .rst(rst), .start(start_a), .busy(busy_a), .lx(lx_a),
        .m0(m0_a), .m1(m1_a), .m2(m2_a), .h(h_a), .ls(ls_a), .lh(lh_a), .done(done_a)
    );

    poly_ctrl #(.MUL_LAT(3), .ADD_LAT(2), .CNT_W(4)) u_b (
        .ck(ck), .rst(rst), .start(start_b), .busy(busy_b), .lx(lx_b),
        .m0(m0_b), .m1(m1_b), .m2(m2_b), .h(h_b), .ls(ls_b), .lh(lh_b), .done(done_b)
    );

    // bit order: busy lx m0 m1 m2 h ls lh done
    logic [11:0] obs_a, obs_b;
    assign obs_a = {busy_a, lx_a, m0_a, m1_a, m2_a, h_a, ls_a, lh_a, done_a};
    assign obs_b = {busy_b, lx_b, m0_b, m1_b, m2_b, h_b, ls_b, lh_b, done_b};

    localparam logic [11:0] V_IDLE   = 12'b0_0_00_00_00_0_0_0_0;
    localparam logic [11:0] V_LOADX  = 12'b1_1_00_00_00_0_0_0_0;
    localparam logic [11:0] V_AX_H   = 12'b1_0_01_00_00_1_0_0_0;
    localparam logic [11:0] V_AX_L   = 12'b1_0_01_00_00_1_0_1_0;
    localparam logic [11:0] V_ADDB_H = 12'b1_0_10_11_01_0_0_0_0;
    localparam logic [11:0] V_ADDB_L = 12'b1_0_10_11_01_0_0_1_0;
    localparam logic [11:0] V_MULX_H = 12'b1_0_00_11_00_1_0_0_0;
    localparam logic [11:0] V_MULX_L = 12'b1_0_00_11_00_1_0_1_0;
    localparam logic [11:0] V_ADDC_H = 12'b1_0_11_11_01_0_0_0_0;
    localparam logic [11:0] V_ADDC_L = 12'b1_0_11_11_01_0_1_0_0;
    localparam logic [11:0] V_DONE   = 12'b1_0_00_00_00_0_0_0_1;

    logic [15:0] xin = '0, ra = '0, rb = '0, rc = '0;
    logic [15:0] xa = '0, sa = '0, ha = '0, xb = '0, sb = '0, hb = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int lx_a_cnt   = 0;
    int ls_a_cnt   = 0;

    typedef struct {
        logic [15:0] y;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [11:0] seq[$];

    function automatic logic [15:0] alu(input logic [1:0] s0, input logic [1:0] s1,
                                        input logic [1:0] s2, input logic op,
                                        input logic [15:0] x, input logic [15:0] s,
                                        input logic [15:0] hr);
        logic [15:0] k, o1, o2;
        logic [31:0] p;
        case (s0)
            2'b00:   k = 16'h0000;
            2'b01:   k = ra;
            2'b10:   k = rb;
            default: k = rc;
        endcase
        case (s1)
            2'b00:   o1 = k;
            2'b01:   o1 = x;
            2'b10:   o1 = s;
            default: o1 = hr;
        endcase
        case (s2)
            2'b00:   o2 = x;
            2'b01:   o2 = k;
            2'b10:   o2 = s;
            default: o2 = hr;
        endcase
        p = o1 * o2;
        return op ? p[15:0] : (o1 + o2);
    endfunction

    function automatic logic [15:0] horner(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] x);
        logic [31:0] p;
        logic [15:0] v;
        p = a * x;
        v = p[15:0] + b;
        p = v * x;
        v = p[15:0] + c;
        return v;
    endfunction

    always @(posedge ck) begin
        if (lx_a) xa <= xin;
        if (lh_a) ha <= alu(m0_a, m1_a, m2_a, h_a, xa, sa, ha);
        if (ls_a) sa <= alu(m0_a, m1_a, m2_a, h_a, xa, sa, ha);
        if (lx_b) xb <= xin;
        if (lh_b) hb <= alu(m0_b, m1_b, m2_b, h_b, xb, sb, hb);
        if (ls_b) sb <= alu(m0_b, m1_b, m2_b, h_b, xb, sb, hb);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge ck);
        cyc++;
        #1;
        if (lx_a) lx_a_cnt++;
        if (ls_a) ls_a_cnt++;
        if (done_a) begin
            if (qa.size() == 0) begin
                checkOutput("a_unexpected_done", 32'(done_a), 0);
            end else begin
                e = qa.pop_front();
                checkOutput("a_done_edge", cyc, e.due);
                checkOutput("a_reg_s", 32'(sa), 32'(e.y));
            end
        end else if (qa.size() != 0 && cyc > qa[0].due) begin
            e = qa.pop_front();
            checkOutput("a_done_missing", 32'(done_a), 1);
        end
        if (done_b) begin
            if (qb.size() == 0) begin
                checkOutput("b_unexpected_done", 32'(done_b), 0);
            end else begin
                e = qb.pop_front();
                checkOutput("b_done_edge", cyc, e.due);
                checkOutput("b_reg_s", 32'(sb), 32'(e.y));
            end
        end else if (qb.size() != 0 && cyc > qb[0].due) begin
            e = qb.pop_front();
            checkOutput("b_done_missing", 32'(done_b), 1);
        end
    endtask

    // Pulses start for one edge; when a result is expected, the scoreboard
    // gets the Horner value and the edge at which DONE must appear.
    task automatic applyStimulus(input bit on_b, input bit expect_done,
                                 input logic [15:0] x, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] c);
        exp_t e;
        int   k;
        xin = x; ra = a; rb = b; rc = c;
        k = cyc + 1;
        e.y = horner(a, b, c, x);
        if (on_b) begin
            e.due = k + 1 + 2 * 3 + 2 * 2;
            if (expect_done) qb.push_back(e);
            start_b = 1'b1;
        end else begin
            e.due = k + 1 + 2 + 2;
            if (expect_done) qa.push_back(e);
            start_a = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic check_seq(input string tag, input bit on_b);
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            checkOutput($sformatf("%s_%0d", tag, i), 32'(on_b ? obs_b : obs_a), 32'(seq[i]));
        end
        seq.delete();
    endtask

    task automatic load_default_seq();
        seq = '{V_LOADX, V_AX_L, V_ADDB_L, V_MULX_L, V_ADDC_L, V_DONE, V_IDLE};
    endtask

    initial begin
        int   lx0, ls0, k;
        exp_t e;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tick();
        tick();
        checkOutput("reset_a", 32'(obs_a), 32'(V_IDLE));
        checkOutput("reset_b", 32'(obs_b), 32'(V_IDLE));
        rst = 1'b1;
        tick();
        checkOutput("idle_a", 32'(obs_a), 32'(V_IDLE));

        $display("[TB] scenario 1: default latencies, X=2 A=3 B=4 C=5");
        applyStimulus(1'b0, 1'b1, 16'd2, 16'd3, 16'd4, 16'd5);
        load_default_seq();
        check_seq("s1", 1'b0);
        checkOutput("s1_y25", 32'(sa), 32'd25);

        $display("[TB] scenario 2: MUL_LAT=3 ADD_LAT=2");
        applyStimulus(1'b1, 1'b1, 16'd2, 16'd3, 16'd4, 16'd5);
        seq = '{V_LOADX, V_AX_H, V_AX_H, V_AX_L, V_ADDB_H, V_ADDB_L,
                V_MULX_H, V_MULX_H, V_MULX_L, V_ADDC_H, V_ADDC_L, V_DONE, V_IDLE};
        check_seq("s2", 1'b1);
        checkOutput("s2_y25", 32'(sb), 32'd25);

        $display("[TB] scenario 3: start held high");
        xin = 16'd2; ra = 16'd3; rb = 16'd4; rc = 16'd5;
        k = cyc + 1;
        e.y = horner(16'd3, 16'd4, 16'd5, 16'd2);
        for (int r = 0; r < 3; r++) begin
            e.due = k + 5 + 7 * r;
            qa.push_back(e);
        end
        lx0 = lx_a_cnt;
        start_a = 1'b1;
        repeat (15) tick();
        start_a = 1'b0;
        repeat (8) tick();
        checkOutput("s3_lx_count", lx_a_cnt - lx0, 3);
        checkOutput("s3_idle", 32'(obs_a), 32'(V_IDLE));

        $display("[TB] scenario 4: reset during MULX");
        applyStimulus(1'b0, 1'b0, 16'd2, 16'd3, 16'd4, 16'd5);
        tick();
        tick();
        tick();
        checkOutput("s4_mulx", 32'(obs_a), 32'(V_MULX_L));
        ls0 = ls_a_cnt;
        rst = 1'b0;
        tick();
        checkOutput("s4_reset_idle", 32'(obs_a), 32'(V_IDLE));
        rst = 1'b1;
        repeat (8) tick();
        checkOutput("s4_no_ls", ls_a_cnt - ls0, 0);

        $display("[TB] scenario 5: X=0, A=B=C=FFFF");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        load_default_seq();
        check_seq("s5", 1'b0);
        checkOutput("s5_y", 32'(sa), 32'h0000FFFF);

        $display("[TB] scenario 6: start pulses in ADDB and DONE");
        applyStimulus(1'b0, 1'b1, 16'd7, 16'd1, 16'd2, 16'd3);
        lx0 = lx_a_cnt;
        tick();
        tick();
        checkOutput("s6_addb", 32'(obs_a), 32'(V_ADDB_L));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checkOutput("s6_mulx", 32'(obs_a), 32'(V_MULX_L));
        tick();
        tick();
        checkOutput("s6_done", 32'(obs_a), 32'(V_DONE));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checkOutput("s6_idle_a", 32'(obs_a), 32'(V_IDLE));
        tick();
        checkOutput("s6_idle_b", 32'(obs_a), 32'(V_IDLE));
        checkOutput("s6_no_retrigger", lx_a_cnt - lx0, 0);

        applyStimulus(1'b0, 1'b1, 16'd3, 16'd2, 16'd1, 16'd4);
        repeat (5) tick();
        checkOutput("s6_done2", 32'(obs_a), 32'(V_DONE));
        e.y = horner(16'd2, 16'd1, 16'd4, 16'd3);
        e.due = cyc + 2 + 5;
        qa.push_back(e);
        start_a = 1'b1;
        tick();
        checkOutput("s6_held_idle", 32'(obs_a), 32'(V_IDLE));
        tick();
        start_a = 1'b0;
        checkOutput("s6_held_loadx", 32'(obs_a), 32'(V_LOADX));
        repeat (7) tick();

        checkOutput("qa_drained", qa.size(), 0);
        checkOutput("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
